// File: rtl/brdg_interrupt_mc.sv
// Multi-channel OpenCAPI interrupt bridge: round-robin arbitrates NUM_CH interrupt sources,
// issues one intrp_req at a time to the TLX AP command port and tracks its response,
// including pending/intrp_rdy handshakes and exponential retry backoff.
module brdg_interrupt_mc #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CHW    = 2,
  parameter int unsigned CTXW   = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [11:0]            cfg_actag_base,
  input  logic [19:0]            cfg_pasid_base,
  input  logic [19:0]            cfg_pasid_mask,
  input  logic [3:0]             backoff_limit,
  input  logic [3:0]             retry_limit,
  input  logic                   interrupt_enable,
  input  logic [NUM_CH-1:0]      interrupt,
  input  logic [NUM_CH*64-1:0]   interrupt_src,
  input  logic [NUM_CH*CTXW-1:0] interrupt_ctx,
  output logic [NUM_CH-1:0]      interrupt_ack,
  output logic [NUM_CH-1:0]      interrupt_fail,
  output logic                   tlx_cmd_valid,
  output logic [67:0]            tlx_cmd_obj,
  output logic [15:0]            tlx_cmd_afutag,
  output logic [7:0]             tlx_cmd_opcode,
  output logic [19:0]            tlx_cmd_pasid,
  output logic [11:0]            tlx_cmd_actag,
  input  logic                   tlx_rsp_valid,
  input  logic [15:0]            tlx_rsp_afutag,
  input  logic [7:0]             tlx_rsp_opcode,
  input  logic [3:0]             tlx_rsp_code
);

  localparam logic [7:0] OpIntrpReq  = 8'h58;
  localparam logic [7:0] OpIntrpResp = 8'h0C;
  localparam logic [7:0] OpIntrpRdy  = 8'h1A;

  typedef enum logic [8:0] {
    StIdle    = 9'h001,
    StArb     = 9'h002,
    StNewInt  = 9'h004,
    StWaitRsp = 9'h008,
    StPending = 9'h010,
    StBackoff = 9'h020,
    StRetry   = 9'h040,
    StAck     = 9'h080,
    StFail    = 9'h100
  } state_e;

  state_e            state_q;
  logic [CHW-1:0]    ptr_q, ch_q;
  logic [63:0]       src_q;
  logic [CTXW-1:0]   ctx_q;
  logic [3:0]        retry_cnt_q;
  logic [23:0]       countdown_q;
  logic [NUM_CH-1:0] ack_q, fail_q;
  logic              cmd_valid_q;
  logic [67:0]       cmd_obj_q;
  logic [15:0]       cmd_afutag_q;
  logic [7:0]        cmd_opcode_q;
  logic [19:0]       cmd_pasid_q;
  logic [11:0]       cmd_actag_q;

  logic              arb_found;
  logic [CHW-1:0]    arb_ch;
  logic [63:0]       arb_src;
  logic [CTXW-1:0]   arb_ctx;
  logic              rsp_hit, int_cur;
  logic              ev_done, ev_retry, ev_pend, ev_rdy, ev_fail;
  logic [3:0]        retry_nxt;
  logic              retry_exhaust;
  logic [4:0]        exp_sum;
  logic [3:0]        exp_sat;
  logic [23:0]       backoff_t;

  // Round-robin scan: channels above the pointer first, then wrap to 0..ptr.
  always_comb begin
    arb_found = 1'b0;
    arb_ch    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!arb_found && interrupt[i] && (i > int'(ptr_q))) begin
        arb_found = 1'b1;
        arb_ch    = CHW'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!arb_found && interrupt[i] && (i <= int'(ptr_q))) begin
        arb_found = 1'b1;
        arb_ch    = CHW'(i);
      end
    end
  end

  // Select the winning channel's object handle and context.
  always_comb begin
    arb_src = '0;
    arb_ctx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_ch == CHW'(i)) begin
        arb_src = interrupt_src[i*64 +: 64];
        arb_ctx = interrupt_ctx[i*CTXW +: CTXW];
      end
    end
  end

  // Response decode, retry accounting and backoff period.
  always_comb begin
    rsp_hit  = tlx_rsp_valid && (tlx_rsp_afutag == {2'b11, 14'(ch_q)});
    int_cur  = interrupt[ch_q];
    ev_done  = 1'b0;
    ev_retry = 1'b0;
    ev_pend  = 1'b0;
    ev_rdy   = 1'b0;
    ev_fail  = 1'b0;
    if (rsp_hit && (state_q == StWaitRsp) && (tlx_rsp_opcode == OpIntrpResp)) begin
      case (tlx_rsp_code)
        4'h0:    ev_done  = 1'b1;
        4'h2:    ev_retry = 1'b1;
        4'h4:    ev_pend  = 1'b1;
        default: ev_fail  = 1'b1;
      endcase
    end else if (rsp_hit && (state_q == StPending) && (tlx_rsp_opcode == OpIntrpRdy)) begin
      case (tlx_rsp_code)
        4'h0:    ev_rdy   = 1'b1;
        4'h2:    ev_retry = 1'b1;
        default: ev_fail  = 1'b1;
      endcase
    end
    retry_nxt     = retry_cnt_q + 4'd1;
    retry_exhaust = (retry_limit != 4'd0) && (retry_nxt == retry_limit);
    // Exponent uses the count before this retry is added.
    exp_sum       = {1'b0, backoff_limit} + {1'b0, retry_cnt_q};
    exp_sat       = (exp_sum > 5'd15) ? 4'd15 : exp_sum[3:0];
    backoff_t     = 24'd20 << exp_sat;
  end

  // Main FSM with registered command and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ptr_q        <= CHW'(NUM_CH - 1);
      ch_q         <= '0;
      src_q        <= '0;
      ctx_q        <= '0;
      retry_cnt_q  <= '0;
      countdown_q  <= '0;
      ack_q        <= '0;
      fail_q       <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_obj_q    <= '0;
      cmd_afutag_q <= '0;
      cmd_opcode_q <= '0;
      cmd_pasid_q  <= '0;
      cmd_actag_q  <= '0;
    end else begin
      cmd_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: if (|interrupt) state_q <= StArb;
        StArb: begin
          if (arb_found) begin
            ch_q        <= arb_ch;
            src_q       <= arb_src;
            ctx_q       <= arb_ctx;
            retry_cnt_q <= '0;
            state_q     <= StNewInt;
          end else begin
            state_q <= StIdle;
          end
        end
        StNewInt: begin
          if (interrupt_enable) begin
            cmd_valid_q  <= 1'b1;
            cmd_obj_q    <= {4'd0, src_q};
            cmd_afutag_q <= {2'b11, 14'(ch_q)};
            cmd_opcode_q <= OpIntrpReq;
            cmd_pasid_q  <= (cfg_pasid_base & cfg_pasid_mask) | (20'(ctx_q) & ~cfg_pasid_mask);
            cmd_actag_q  <= cfg_actag_base + 12'(ctx_q);
            state_q      <= StWaitRsp;
          end
        end
        StWaitRsp, StPending: begin
          if (ev_done) begin
            ack_q[ch_q] <= 1'b1;
            state_q     <= StAck;
          end else if (ev_pend) begin
            state_q <= StPending;
          end else if (ev_rdy) begin
            state_q <= StRetry;
          end else if (ev_retry) begin
            retry_cnt_q <= retry_nxt;
            if (retry_exhaust) begin
              ack_q[ch_q]  <= 1'b1;
              fail_q[ch_q] <= 1'b1;
              state_q      <= StFail;
            end else begin
              countdown_q <= backoff_t;
              state_q     <= StBackoff;
            end
          end else if (ev_fail) begin
            ack_q[ch_q]  <= 1'b1;
            fail_q[ch_q] <= 1'b1;
            state_q      <= StFail;
          end
        end
        StBackoff: begin
          if (countdown_q == 24'd0) state_q <= StRetry;
          else countdown_q <= countdown_q - 24'd1;
        end
        StRetry: state_q <= StNewInt;
        StAck, StFail: begin
          // Completion is held until the source withdraws its request.
          if (!int_cur) begin
            ack_q   <= '0;
            fail_q  <= '0;
            ptr_q   <= ch_q;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign interrupt_ack  = ack_q;
  assign interrupt_fail = fail_q;
  assign tlx_cmd_valid  = cmd_valid_q;
  assign tlx_cmd_obj    = cmd_obj_q;
  assign tlx_cmd_afutag = cmd_afutag_q;
  assign tlx_cmd_opcode = cmd_opcode_q;
  assign tlx_cmd_pasid  = cmd_pasid_q;
  assign tlx_cmd_actag  = cmd_actag_q;

endmodule

// File: tb/tb_brdg_interrupt_mc.sv
// Self-checking bench for brdg_interrupt_mc: random sources and responses, checked against a
// transaction-level model of arbitration order, command contents and backoff timing.
module tb_brdg_interrupt_mc;

  localparam int NUM_CH = 4;
  localparam int CHW    = 2;
  localparam int CTXW   = 9;

  logic                   clk;
  logic                   rst_n;
  logic [11:0]            cfg_actag_base;
  logic [19:0]            cfg_pasid_base, cfg_pasid_mask;
  logic [3:0]             backoff_limit, retry_limit;
  logic                   interrupt_enable;
  logic [NUM_CH-1:0]      interrupt;
  logic [NUM_CH*64-1:0]   interrupt_src;
  logic [NUM_CH*CTXW-1:0] interrupt_ctx;
  logic [NUM_CH-1:0]      interrupt_ack, interrupt_fail;
  logic                   tlx_cmd_valid;
  logic [67:0]            tlx_cmd_obj;
  logic [15:0]            tlx_cmd_afutag;
  logic [7:0]             tlx_cmd_opcode;
  logic [19:0]            tlx_cmd_pasid;
  logic [11:0]            tlx_cmd_actag;
  logic                   tlx_rsp_valid;
  logic [15:0]            tlx_rsp_afutag;
  logic [7:0]             tlx_rsp_opcode;
  logic [3:0]             tlx_rsp_code;

  brdg_interrupt_mc #(.NUM_CH(NUM_CH), .CHW(CHW), .CTXW(CTXW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_actag_base   (cfg_actag_base),
    .cfg_pasid_base   (cfg_pasid_base),
    .cfg_pasid_mask   (cfg_pasid_mask),
    .backoff_limit    (backoff_limit),
    .retry_limit      (retry_limit),
    .interrupt_enable (interrupt_enable),
    .interrupt        (interrupt),
    .interrupt_src    (interrupt_src),
    .interrupt_ctx    (interrupt_ctx),
    .interrupt_ack    (interrupt_ack),
    .interrupt_fail   (interrupt_fail),
    .tlx_cmd_valid    (tlx_cmd_valid),
    .tlx_cmd_obj      (tlx_cmd_obj),
    .tlx_cmd_afutag   (tlx_cmd_afutag),
    .tlx_cmd_opcode   (tlx_cmd_opcode),
    .tlx_cmd_pasid    (tlx_cmd_pasid),
    .tlx_cmd_actag    (tlx_cmd_actag),
    .tlx_rsp_valid    (tlx_rsp_valid),
    .tlx_rsp_afutag   (tlx_rsp_afutag),
    .tlx_rsp_opcode   (tlx_rsp_opcode),
    .tlx_rsp_code     (tlx_rsp_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [67:0] obj;
    logic [15:0] tag;
    logic [7:0]  op;
    logic [19:0] pasid;
    logic [11:0] actag;
  } cmd_t;

  cmd_t cmd_q[$];
  cmd_t mon_c;

  // Capture every command strobe with the cycle it appeared in.
  always @(negedge clk) begin
    if (tlx_cmd_valid) begin
      mon_c.cyc   = cyc;
      mon_c.obj   = tlx_cmd_obj;
      mon_c.tag   = tlx_cmd_afutag;
      mon_c.op    = tlx_cmd_opcode;
      mon_c.pasid = tlx_cmd_pasid;
      mon_c.actag = tlx_cmd_actag;
      cmd_q.push_back(mon_c);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int ptr_m;
  logic [3:0] fail_codes [6] = '{4'h1, 4'h3, 4'h8, 4'h9, 4'hB, 4'hE};

  task automatic check_eq(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [NUM_CH-1:0] req);
    int c;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (ptr_m + k) % NUM_CH;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] tag_of(input int ch);
    return 16'hC000 + 16'(ch);
  endfunction

  function automatic int backoff_cycles(input int bl, input int k);
    int e;
    e = bl + k;
    if (e > 15) e = 15;
    return 20 * (1 << e);
  endfunction

  task automatic expect_cmd(input int ch, input int exp_cyc);
    int   waited;
    int   ctx;
    cmd_t c;
    logic [19:0] ctx20;
    waited = 0;
    while (cmd_q.size() == 0 && waited < 2000) begin
      tick();
      waited++;
    end
    check_eq("cmd_seen", 68'(cmd_q.size() > 0), 68'(1));
    if (cmd_q.size() == 0) return;
    c     = cmd_q.pop_front();
    ctx   = int'(interrupt_ctx[ch*CTXW +: CTXW]);
    ctx20 = 20'(ctx);
    check_eq("cmd_afutag", c.tag, tag_of(ch));
    check_eq("cmd_opcode", c.op, 8'h58);
    check_eq("cmd_obj", c.obj, {4'd0, interrupt_src[ch*64 +: 64]});
    check_eq("cmd_pasid", c.pasid, (cfg_pasid_base & cfg_pasid_mask) | (ctx20 & ~cfg_pasid_mask));
    check_eq("cmd_actag", c.actag, 12'((int'(cfg_actag_base) + ctx) % 4096));
    if (exp_cyc >= 0) check_eq("cmd_time", c.cyc, exp_cyc);
  endtask

  task automatic respond(input logic [7:0] op, input logic [3:0] code, input logic [15:0] tag,
                         output int edge_cyc);
    tlx_rsp_valid  = 1'b1;
    tlx_rsp_opcode = op;
    tlx_rsp_code   = code;
    tlx_rsp_afutag = tag;
    edge_cyc       = cyc + 1;
    tick();
    tlx_rsp_valid  = 1'b0;
  endtask

  task automatic raise(input int ch, output int edge_cyc);
    interrupt[ch] = 1'b1;
    edge_cyc      = cyc + 1;
  endtask

  task automatic expect_ack(input int ch, input bit f);
    logic [NUM_CH-1:0] onehot;
    onehot = NUM_CH'(1) << ch;
    check_eq("ack", interrupt_ack, onehot);
    check_eq("fail", interrupt_fail, f ? onehot : '0);
    repeat ($urandom_range(1, 4)) tick();
    check_eq("ack_hold", {interrupt_fail, interrupt_ack}, {(f ? onehot : NUM_CH'(0)), onehot});
    check_eq("no_extra_cmd", 68'(cmd_q.size()), 68'(0));
    interrupt[ch] = 1'b0;
    tick();
    check_eq("ack_clr", {interrupt_fail, interrupt_ack}, 68'(0));
    ptr_m = ch;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ack"}, {interrupt_fail, interrupt_ack}, 68'(0));
    check_eq({tag, "_valid"}, tlx_cmd_valid, 68'(0));
    check_eq({tag, "_obj"}, tlx_cmd_obj, 68'(0));
    check_eq({tag, "_cmd"}, {tlx_cmd_afutag, tlx_cmd_opcode, tlx_cmd_pasid, tlx_cmd_actag},
             68'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
    $fatal(1);
  end

  initial begin
    int e, ch, mode, other, nret, bl, lim;
    logic [NUM_CH-1:0] mask;
    bit first;

    rst_n            = 1'b0;
    interrupt        = '0;
    interrupt_enable = 1'b1;
    backoff_limit    = 4'd0;
    retry_limit      = 4'd0;
    tlx_rsp_valid    = 1'b0;
    tlx_rsp_afutag   = '0;
    tlx_rsp_opcode   = '0;
    tlx_rsp_code     = '0;
    cfg_actag_base   = 12'($urandom);
    cfg_pasid_base   = 20'($urandom);
    cfg_pasid_mask   = 20'($urandom);
    for (int i = 0; i < NUM_CH; i++) begin
      interrupt_src[i*64 +: 64]     = {$urandom, $urandom};
      interrupt_ctx[i*CTXW +: CTXW] = CTXW'($urandom);
    end
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    ptr_m = NUM_CH - 1;
    tick();

    // Single channel, immediate done.
    raise(2, e);
    expect_cmd(2, e + 2);
    respond(8'h0C, 4'h0, tag_of(2), e);
    expect_ack(2, 1'b0);

    // Round-robin rounds with random response flavours.
    for (int r = 0; r < 8; r++) begin
      mask = (r == 0) ? 4'b1011 : NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      interrupt = mask;
      e = cyc + 1;
      first = 1'b1;
      while (mask != 0) begin
        ch = rr_pick(mask);
        expect_cmd(ch, first ? e + 2 : -1);
        first = 1'b0;
        other = (ch + 1) % NUM_CH;
        respond(8'h0C, 4'h0, tag_of(other), e);
        check_eq("ignore_foreign_tag", interrupt_ack, 68'(0));
        mode = $urandom_range(0, 3);
        case (mode)
          0: begin
            respond(8'h0C, 4'h0, tag_of(ch), e);
            expect_ack(ch, 1'b0);
          end
          1: begin
            respond(8'h0C, fail_codes[$urandom_range(0, 5)], tag_of(ch), e);
            expect_ack(ch, 1'b1);
          end
          2: begin
            respond(8'h0C, 4'h4, tag_of(ch), e);
            repeat ($urandom_range(0, 3)) tick();
            respond(8'h1A, 4'h0, tag_of(ch), e);
            expect_cmd(ch, e + 2);
            respond(8'h0C, 4'h0, tag_of(ch), e);
            expect_ack(ch, 1'b0);
          end
          default: begin
            respond(8'h0C, 4'h4, tag_of(ch), e);
            respond(8'h1A, fail_codes[$urandom_range(0, 5)], tag_of(ch), e);
            expect_ack(ch, 1'b1);
          end
        endcase
        mask[ch] = 1'b0;
      end
    end

    // Exponential backoff with unlimited retries.
    for (int run = 0; run < 2; run++) begin
      bl   = (run == 0) ? 0 : $urandom_range(0, 2);
      nret = (run == 0) ? 2 : $urandom_range(1, 3);
      ch   = (run == 0) ? 1 : $urandom_range(0, NUM_CH - 1);
      backoff_limit = 4'(bl);
      retry_limit   = 4'd0;
      raise(ch, e);
      expect_cmd(ch, e + 2);
      for (int k = 0; k < nret; k++) begin
        respond(8'h0C, 4'h2, tag_of(ch), e);
        expect_cmd(ch, e + backoff_cycles(bl, k) + 3);
      end
      respond(8'h0C, 4'h0, tag_of(ch), e);
      expect_ack(ch, 1'b0);
    end

    // Retry limit turns the final retry response into a failure.
    for (int run = 0; run < 2; run++) begin
      lim = (run == 0) ? 2 : $urandom_range(1, 3);
      ch  = (run == 0) ? 0 : $urandom_range(0, NUM_CH - 1);
      backoff_limit = 4'd0;
      retry_limit   = 4'(lim);
      raise(ch, e);
      expect_cmd(ch, e + 2);
      respond(8'h0C, 4'h0, tag_of((ch + 1) % NUM_CH), e);
      check_eq("limit_foreign_tag", interrupt_ack, 68'(0));
      for (int k = 0; k < lim; k++) begin
        respond(8'h0C, 4'h2, tag_of(ch), e);
        if (k < lim - 1) expect_cmd(ch, e + backoff_cycles(0, k) + 3);
      end
      expect_ack(ch, 1'b1);
    end

    // Issue gated by enable, then reset in the middle of a backoff.
    retry_limit      = 4'd0;
    backoff_limit    = 4'd2;
    interrupt_enable = 1'b0;
    ch = $urandom_range(0, NUM_CH - 1);
    raise(ch, e);
    repeat (50) tick();
    check_eq("no_cmd_disabled", 68'(cmd_q.size()), 68'(0));
    interrupt_enable = 1'b1;
    e = cyc + 1;
    expect_cmd(ch, e);
    respond(8'h0C, 4'h2, tag_of(ch), e);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    interrupt = '0;
    tick();
    rst_n = 1'b1;
    ptr_m = NUM_CH - 1;
    respond(8'h0C, 4'h0, tag_of(ch), e);
    repeat (5) tick();
    check_eq("late_rsp_ack", {interrupt_fail, interrupt_ack}, 68'(0));
    check_eq("late_rsp_cmd", 68'(cmd_q.size()), 68'(0));
    ch = $urandom_range(0, NUM_CH - 1);
    raise(ch, e);
    expect_cmd(ch, e + 2);
    respond(8'h0C, 4'h0, tag_of(ch), e);
    expect_ack(ch, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
